vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the 100 MHz board clock and supplies the pixel coordinate bus (x, y) consumed by every glyph/paddle/ball renderer. Renderers compare the x/y bus against their own start_x/start_y and assert display; the pixel mux gates their OR with video_on. Also provides a once-per-frame vblank_tick, which game logic uses to update object positions while nothing is drawn.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz)
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- x  output  10  current horizontal count, 0..H_TOTAL-1
- y  output  10  current vertical count, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video_on  output  1  high when x < H_DISPLAY and y < V_DISPLAY
- p_tick  output  1  one-clk pulse, once per pixel period
- vblank_tick  output  1  one-clk pulse on entry to (x=0, y=V_DISPLAY)

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Both must be ≤ 1024; counters are 10 bits, unsigned.
- Divider: div counts 0..TICK_DIV-1, wraps to 0. p_tick = (div == TICK_DIV-1), combinational from div register.
- Horizontal: on p_tick, h = (h == H_TOTAL-1) ? 0 : h+1.
- Vertical: on p_tick with h == H_TOTAL-1, v = (v == V_TOTAL-1) ? 0 : v+1. Otherwise v holds.
- x = h, y = v (registers driven directly).
- hsync low iff H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync low iff V_DISPLAY+V_FRONT ≤ v < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- hsync, vsync, video_on are registers, computed from the next-state counter values, so they change in the same clk edge as x/y; no combinational decode on outputs (glitch-free pins).
- vblank_tick: registered, high for exactly one clk in the first cycle that h=0, v=V_DISPLAY holds; low otherwise.
- Reset (sync, dominant over all): div=0, h=0, v=0, hsync=1, vsync=1, video_on=1, vblank_tick=0; p_tick=0 follows from div=0. Reset asserted mid-frame restarts at (0,0) on the next edge with no partial sync pulse extended.

## Timing
- Each (x, y) value held for exactly TICK_DIV clks; p_tick is high in the last clk of that hold; counters advance on the edge ending it.
- After reset release: p_tick high in clk 3 (counting release clk as 0); x becomes 1 at clk 4.
- Line = 800 p_ticks = 3200 clk; frame = 525 lines = 420,000 p_ticks = 1,680,000 clk (~59.52 Hz).
- hsync low for 96 pixels (384 clk) per line; vsync low for 2 full lines (1600 p_ticks), beginning with the edge where x goes 799→0 and y goes 489→490.
- video_on falls with the edge x 639→640 and rises with the edge x 799→0 on lines 0..478 and 524→0.
- vblank_tick period = 1,680,000 clk, exactly one pulse per frame.
- Renderer path: x/y change on clk edge; downstream display sampled within same pixel hold (TICK_DIV-1 clks of slack).

## Test plan
- Reset: hold reset 3 clks mid-run -> next clk x=0, y=0, hsync=1, vsync=1, video_on=1, vblank_tick=0, p_tick=0; p_tick first high 3 clks after release.
- Pixel cadence: free-run 40 clks -> p_tick every 4th clk, x steps 0..9, each value held 4 clks.
- Line timing: run through one line -> hsync falls on x 655→656, rises on 751→752 (96 pixels); video_on falls at x=640; x wraps 799→0 while y increments 0→1.
- Frame timing: run one full frame -> vsync low only for y=490,491 (1600 p_ticks); y wraps 524→0 together with x 799→0; video_on never high when y ≥ 480.
- vblank_tick: run 2 frames -> exactly 2 pulses, 1,680,000 clks apart, each coincident with x=0, y=480 first cycle, one clk wide.
- Reset mid-sync: assert reset while x=700, y=490 (hsync and vsync low) -> both return high next edge; counters restart at 0,0; next hsync low at x=656.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters and glitch-free registered sync/blank outputs.
// Defaults give 640x480@60 Hz from a 100 MHz clock (25 MHz pixel rate).
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned TICK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       vblank_tick
);

  localparam int unsigned CW       = 10;
  localparam int unsigned DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = V_DISPLAY + V_FRONT + V_SYNC;

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          vblank_tick_q, vblank_tick_d;
  logic          h_last;

  assign p_tick = (div_q == DW'(TICK_DIV - 1));
  assign h_last = (h_q == CW'(H_TOTAL - 1));

  // Next-state counters; sync/blank decode works on the next values so pins change with x/y.
  always_comb begin
    div_d = div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (p_tick) begin
      div_d = '0;
      h_d   = h_last ? '0 : h_q + CW'(1);
      if (h_last) begin
        v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
      end
    end
    hsync_d       = !((h_d >= CW'(HS_START)) && (h_d < CW'(HS_END)));
    vsync_d       = !((v_d >= CW'(VS_START)) && (v_d < CW'(VS_END)));
    video_on_d    = (h_d < CW'(H_DISPLAY)) && (v_d < CW'(V_DISPLAY));
    vblank_tick_d = p_tick && (h_d == '0) && (v_d == CW'(V_DISPLAY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      vblank_tick_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      vblank_tick_q <= vblank_tick_d;
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign vblank_tick = vblank_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for pixel/line timing, shrunken instance for frame/vsync/vblank.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       vb;
  } exp_t;

  // Shrunken timing: 16+2+4+3 = 25 pixels/line, 8+2+2+3 = 15 lines, 1500 clks/frame.
  localparam int S_HD = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VD = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB) * 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] x, y, xs, ys;
  logic hsync, vsync, video_on, p_tick, vblank_tick;
  logic hsync_s, vsync_s, video_on_s, p_tick_s, vblank_tick_s;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_tick(p_tick), .vblank_tick(vblank_tick)
  );

  vga_sync_gen #(
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .TICK_DIV(4)
  ) dut_s (
    .clk(clk), .reset(reset), .x(xs), .y(ys), .hsync(hsync_s), .vsync(vsync_s),
    .video_on(video_on_s), .p_tick(p_tick_s), .vblank_tick(vblank_tick_s)
  );

  int   checks = 0;
  int   fails  = 0;
  int   t      = 0;
  int   cyc    = 0;
  exp_t q_d[$];
  exp_t q_s[$];

  int hs_low_line0, vs_low_pix, vb_count, vb_last, vb_gap;

  // Reference timing from clocks elapsed since reset (independent of counter structure).
  function automatic exp_t model(int tt, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb, int td);
    exp_t m;
    int ht  = hd + hf + hs + hb;
    int vt  = vd + vf + vs + vb;
    int pix = tt / td;
    int px  = pix % ht;
    int py  = (pix / ht) % vt;
    m.x  = 10'(px);
    m.y  = 10'(py);
    m.hs = (px >= hd + hf && px < hd + hf + hs) ? 1'b0 : 1'b1;
    m.vs = (py >= vd + vf && py < vd + vf + vs) ? 1'b0 : 1'b1;
    m.vo = (px < hd && py < vd) ? 1'b1 : 1'b0;
    m.pt = ((tt % td) == td - 1) ? 1'b1 : 1'b0;
    m.vb = ((tt % td) == 0 && px == 0 && py == vd) ? 1'b1 : 1'b0;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input exp_t o);
    chk({who, ".x"}, 32'(o.x), 32'(e.x));
    chk({who, ".y"}, 32'(o.y), 32'(e.y));
    chk({who, ".hsync"}, 32'(o.hs), 32'(e.hs));
    chk({who, ".vsync"}, 32'(o.vs), 32'(e.vs));
    chk({who, ".video_on"}, 32'(o.vo), 32'(e.vo));
    chk({who, ".p_tick"}, 32'(o.pt), 32'(e.pt));
    chk({who, ".vblank_tick"}, 32'(o.vb), 32'(e.vb));
  endtask

  // One clock: predict, push, clock, pop and compare, then update event tallies.
  task automatic step();
    exp_t o;
    t = reset ? 0 : t + 1;
    q_d.push_back(model(t, 640, 16, 96, 48, 480, 10, 2, 33, 4));
    q_s.push_back(model(t, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 4));
    @(posedge clk);
    #1;
    cyc++;
    o = '{x, y, hsync, vsync, video_on, p_tick, vblank_tick};
    cmp("full", q_d.pop_front(), o);
    o = '{xs, ys, hsync_s, vsync_s, video_on_s, p_tick_s, vblank_tick_s};
    cmp("small", q_s.pop_front(), o);
    if (!hsync && y == 10'd0) hs_low_line0++;
    if (!vsync_s && p_tick_s && t < S_FRAME) vs_low_pix++;
    if (vblank_tick_s) begin
      if (vb_count > 0) vb_gap = cyc - vb_last;
      vb_last = cyc;
      vb_count++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    // Power-on reset, then pixel cadence.
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(40);
    chk("cadence.x_after_40", 32'(x), 32'd10);

    // Reset held 3 clocks mid-run.
    run(17);
    reset = 1'b1;
    run(3);
    chk("reset.x", 32'(x), 32'd0);
    chk("reset.p_tick", 32'(p_tick), 32'd0);
    reset = 1'b0;

    // One full-size line plus two small frames.
    hs_low_line0 = 0; vs_low_pix = 0; vb_count = 0; vb_last = 0; vb_gap = 0;
    run(3400);
    chk("line.hsync_low_clks", 32'(hs_low_line0), 32'd384);
    chk("line.y_after_wrap", 32'(y), 32'd1);
    chk("frame.vsync_low_pixels", 32'(vs_low_pix), 32'(2 * (S_HD + S_HF + S_HS + S_HB)));
    chk("vblank.count", 32'(vb_count), 32'd2);
    chk("vblank.gap", 32'(vb_gap), 32'(S_FRAME));

    // Reset while both syncs are low on the small instance.
    found = 1'b0;
    for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
      if (!hsync_s && !vsync_s) found = 1'b1;
      else step();
    end
    chk("midsync.reached", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midsync.hsync", 32'(hsync_s), 32'd1);
    chk("midsync.vsync", 32'(vsync_s), 32'd1);
    chk("midsync.xy", 32'({xs, ys}), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (!hsync_s) found = 1'b1;
    end
    chk("midsync.hsync_again", 32'(found), 32'd1);
    chk("midsync.hsync_x", 32'(xs), 32'(S_HD + S_HF));
    chk("midsync.hsync_t", 32'(t), 32'((S_HD + S_HF) * 4));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
